// File: rtl/mr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mr_pkg
//  Description : Shared types and constants for the writeback controller and
//                its scoreboard. XLEN_DEF / REGSEL_BITS_DEF mirror the core's
//                configuration values (32-bit data, 32 architectural regs).
//  Contents    : wb_src_e     - writeback source identifier (ALU / MEM)
//                PEND_BITS_DEF- default width of a per-register pending count
//                REG_ZERO     - index of the hardwired-zero register x0
//                other_src()  - returns the opposite writeback source
//  Revision    : 1.0  initial release
// ============================================================================
package mr_pkg;

   localparam int XLEN_DEF        = 32;
   localparam int REGSEL_BITS_DEF = 5;
   localparam int PEND_BITS_DEF   = 2;
   localparam int REG_ZERO        = 0;

   typedef enum logic {
      WBSRC_ALU = 1'b0,
      WBSRC_MEM = 1'b1
   } wb_src_e;

   function automatic wb_src_e other_src(input wb_src_e s);
      return (s == WBSRC_ALU) ? WBSRC_MEM : WBSRC_ALU;
   endfunction

endpackage : mr_pkg
`default_nettype wire

// File: rtl/mr_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : mr_scoreboard
//  Description : Per-register pending-write scoreboard. Each register 1..N-1
//                owns a PEND_BITS saturating-by-construction counter that is
//                incremented when decode issues a writer and decremented when
//                the register file is written. x0 never counts.
//  Ports       : clk, rst          - clock, async active-high reset
//                i_issue_valid     - decode issuing an instruction with a dest
//                i_issue_reg       - destination register of that instruction
//                o_issue_ready     - counter for i_issue_reg has room
//                i_dec_valid       - register-file write strobe (decrement)
//                i_dec_reg         - register-file write index
//                i_rs1 / i_rs2     - decode source registers
//                o_rs1_busy/o_rs2_busy - source has an outstanding write
//                o_sb_err          - sticky: decrement of an empty counter
//  Revision    : 1.0  initial release
// ============================================================================
module mr_scoreboard
   import mr_pkg::*;
#(
   parameter int REGSEL_BITS = REGSEL_BITS_DEF,
   parameter int PEND_BITS   = PEND_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_issue_valid,
   input  logic [REGSEL_BITS-1:0] i_issue_reg,
   output logic                   o_issue_ready,
   input  logic                   i_dec_valid,
   input  logic [REGSEL_BITS-1:0] i_dec_reg,
   input  logic [REGSEL_BITS-1:0] i_rs1,
   input  logic [REGSEL_BITS-1:0] i_rs2,
   output logic                   o_rs1_busy,
   output logic                   o_rs2_busy,
   output logic                   o_sb_err
);

   localparam int                   c_nregs    = 2 ** REGSEL_BITS;
   localparam logic [PEND_BITS-1:0] c_pend_max = '1;
   localparam logic [REGSEL_BITS-1:0] c_reg_zero = REGSEL_BITS'(REG_ZERO);

   logic [PEND_BITS-1:0] r_pend     [c_nregs];
   logic [PEND_BITS-1:0] w_pend_nxt [c_nregs];
   logic                 r_sb_err;

   logic                 w_inc;
   logic [c_nregs-1:0]   w_inc_vec;
   logic [c_nregs-1:0]   w_dec_vec;
   logic [c_nregs-1:0]   w_uflow_vec;

   // Ready is withheld during reset so nothing is recorded against counters
   // that are being cleared.
   assign o_issue_ready = !rst &&
                          ((i_issue_reg == c_reg_zero) ||
                           (r_pend[i_issue_reg] != c_pend_max));

   assign w_inc = i_issue_valid && o_issue_ready && (i_issue_reg != c_reg_zero);

   // One-hot views of the increment / decrement targets. Bit 0 of the
   // decrement vector is masked so x0 can never be touched even if a stray
   // strobe named it.
   assign w_inc_vec = w_inc ? (c_nregs'(1) << i_issue_reg) : '0;
   assign w_dec_vec = i_dec_valid ? ((c_nregs'(1) << i_dec_reg) & ~c_nregs'(1)) : '0;

   always_comb begin
      for (int r = 0; r < c_nregs; r++) begin
         w_pend_nxt[r]  = r_pend[r];
         w_uflow_vec[r] = 1'b0;
         if (w_inc_vec[r] && !w_dec_vec[r]) begin
            w_pend_nxt[r] = r_pend[r] + PEND_BITS'(1);
         end else if (w_dec_vec[r] && !w_inc_vec[r]) begin
            // An empty counter stays at zero; the mismatch is only reported.
            if (r_pend[r] != '0) begin
               w_pend_nxt[r] = r_pend[r] - PEND_BITS'(1);
            end else begin
               w_uflow_vec[r] = 1'b1;
            end
         end
         // Simultaneous issue and writeback of the same register cancel out.
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < c_nregs; r++) begin
            r_pend[r] <= '0;
         end
         r_sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < c_nregs; r++) begin
            r_pend[r] <= w_pend_nxt[r];
         end
         r_sb_err <= r_sb_err | (|w_uflow_vec);
      end
   end

   // No bypass: a register reads not-busy only after the counter has dropped,
   // which is the same edge at which the register file holds the new value.
   assign o_rs1_busy = (i_rs1 != c_reg_zero) && (r_pend[i_rs1] != '0);
   assign o_rs2_busy = (i_rs2 != c_reg_zero) && (r_pend[i_rs2] != '0);
   assign o_sb_err   = r_sb_err;

endmodule : mr_scoreboard
`default_nettype wire

// File: rtl/mr_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mr_wb_ctrl
//  Description : Writeback controller. Arbitrates ALU and load results onto
//                the single register-file write port (1-cycle latency, one
//                write per cycle) and hosts the pending-write scoreboard used
//                by decode for RAW stalls and issue throttling.
//  Build macro : MR_WB_RR_EN - defined: round-robin arbitration on contention;
//                undefined: fixed priority, loads (MEM) over ALU.
//  Ports       : clk, rst                        - clock, async active-high reset
//                alu_wb_valid/ready/reg/val      - ALU writeback source
//                mem_wb_valid/ready/reg/val      - load writeback source
//                wb_valid/wb_reg/wb_val          - registered register-file write
//                issue_valid/ready/reg           - decode destination issue
//                rs1/rs2, rs1_busy/rs2_busy      - source hazard lookup
//                sb_err                          - sticky scoreboard underflow
//  Revision    : 1.0  initial release
// ============================================================================
module mr_wb_ctrl
   import mr_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int REGSEL_BITS = REGSEL_BITS_DEF,
   parameter int PEND_BITS   = PEND_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_wb_valid,
   output logic                   alu_wb_ready,
   input  logic [REGSEL_BITS-1:0] alu_wb_reg,
   input  logic [XLEN-1:0]        alu_wb_val,
   input  logic                   mem_wb_valid,
   output logic                   mem_wb_ready,
   input  logic [REGSEL_BITS-1:0] mem_wb_reg,
   input  logic [XLEN-1:0]        mem_wb_val,
   output logic                   wb_valid,
   output logic [REGSEL_BITS-1:0] wb_reg,
   output logic [XLEN-1:0]        wb_val,
   input  logic                   issue_valid,
   output logic                   issue_ready,
   input  logic [REGSEL_BITS-1:0] issue_reg,
   input  logic [REGSEL_BITS-1:0] rs1,
   input  logic [REGSEL_BITS-1:0] rs2,
   output logic                   rs1_busy,
   output logic                   rs2_busy,
   output logic                   sb_err
);

   localparam logic [REGSEL_BITS-1:0] c_reg_zero = REGSEL_BITS'(REG_ZERO);

   wb_src_e                w_winner;
   logic                   w_contended;
   logic                   w_alu_xfer;
   logic                   w_mem_xfer;
   logic [REGSEL_BITS-1:0] w_xfer_reg;
   logic [XLEN-1:0]        w_xfer_val;

   logic                   r_wb_valid;
   logic [REGSEL_BITS-1:0] r_wb_reg;
   logic [XLEN-1:0]        r_wb_val;

   assign w_contended = alu_wb_valid && mem_wb_valid;

   // ------------------------------------------------------------------------
   // Arbitration. The winner is only meaningful on contention; with a single
   // requester that requester is picked, and with none the default is ALU.
   // ------------------------------------------------------------------------
`ifdef MR_WB_RR_EN
   wb_src_e r_rr_ptr;

   always_comb begin
      w_winner = WBSRC_ALU;
      if (w_contended) begin
         w_winner = r_rr_ptr;
      end else if (mem_wb_valid) begin
         w_winner = WBSRC_MEM;
      end
   end

   // A contested cycle always grants someone (outside reset), so the pointer
   // moves on every contested cycle and stays put otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= WBSRC_ALU;
      end else if (w_contended) begin
         r_rr_ptr <= other_src(r_rr_ptr);
      end
   end
`else
   // Loads win so the memory pipe drains first.
   always_comb begin
      w_winner = mem_wb_valid ? WBSRC_MEM : WBSRC_ALU;
   end
`endif

   // A source is refused only when the other one is present and wins.
   assign alu_wb_ready = !rst && (!mem_wb_valid || (w_winner == WBSRC_ALU));
   assign mem_wb_ready = !rst && (!alu_wb_valid || (w_winner == WBSRC_MEM));

   assign w_alu_xfer = alu_wb_valid && alu_wb_ready;
   assign w_mem_xfer = mem_wb_valid && mem_wb_ready;

   assign w_xfer_reg = w_mem_xfer ? mem_wb_reg : alu_wb_reg;
   assign w_xfer_val = w_mem_xfer ? mem_wb_val : alu_wb_val;

   // ------------------------------------------------------------------------
   // Register-file write port. An accepted x0 result updates the index/data
   // holding registers but produces no strobe, so the scoreboard never sees
   // a decrement for x0.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_reg   <= '0;
         r_wb_val   <= '0;
      end else if (w_alu_xfer || w_mem_xfer) begin
         r_wb_valid <= (w_xfer_reg != c_reg_zero);
         r_wb_reg   <= w_xfer_reg;
         r_wb_val   <= w_xfer_val;
      end else begin
         r_wb_valid <= 1'b0;
      end
   end

   assign wb_valid = r_wb_valid;
   assign wb_reg   = r_wb_reg;
   assign wb_val   = r_wb_val;

   // ------------------------------------------------------------------------
   // Scoreboard. Decrements are driven by the registered write strobe, i.e.
   // on the edge where the register file captures the value.
   // ------------------------------------------------------------------------
   mr_scoreboard #(
      .REGSEL_BITS (REGSEL_BITS),
      .PEND_BITS   (PEND_BITS)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .i_issue_valid (issue_valid),
      .i_issue_reg   (issue_reg),
      .o_issue_ready (issue_ready),
      .i_dec_valid   (r_wb_valid),
      .i_dec_reg     (r_wb_reg),
      .i_rs1         (rs1),
      .i_rs2         (rs2),
      .o_rs1_busy    (rs1_busy),
      .o_rs2_busy    (rs2_busy),
      .o_sb_err      (sb_err)
   );

endmodule : mr_wb_ctrl
`default_nettype wire

// File: tb/tb_mr_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mr_wb_ctrl
//  Description : Self-checking bench for mr_wb_ctrl. A behavioural model of the
//                writeback port and per-register pending counts is checked
//                against the DUT on every falling edge; directed sequences add
//                hand-computed literal expectations. Honours MR_WB_RR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mr_wb_ctrl;

   localparam int XLEN = 32;
   localparam int RS   = 5;
   localparam int PB   = 2;
   localparam int MAXP = (1 << PB) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            alu_wb_valid = 1'b0, mem_wb_valid = 1'b0;
   logic            alu_wb_ready, mem_wb_ready;
   logic [RS-1:0]   alu_wb_reg = '0, mem_wb_reg = '0;
   logic [XLEN-1:0] alu_wb_val = '0, mem_wb_val = '0;
   logic            wb_valid;
   logic [RS-1:0]   wb_reg;
   logic [XLEN-1:0] wb_val;
   logic            issue_valid = 1'b0;
   logic            issue_ready;
   logic [RS-1:0]   issue_reg = '0;
   logic [RS-1:0]   rs1 = '0, rs2 = '0;
   logic            rs1_busy, rs2_busy, sb_err;

   always #5 clk = ~clk;

   mr_wb_ctrl #(.XLEN(XLEN), .REGSEL_BITS(RS), .PEND_BITS(PB)) dut (
      .clk(clk), .rst(rst),
      .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
      .alu_wb_reg(alu_wb_reg), .alu_wb_val(alu_wb_val),
      .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
      .mem_wb_reg(mem_wb_reg), .mem_wb_val(mem_wb_val),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_reg(issue_reg),
      .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .sb_err(sb_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int              pend_m [32];
   bit              err_m = 0;
   bit              m_wbv = 0;
   logic [RS-1:0]   m_wbr = '0;
   logic [XLEN-1:0] m_wbd = '0;
   bit              m_rr  = 0;   // 0 = ALU next on contention, 1 = MEM
   int              m_win;
   bit              m_inc;

   // 0 = no grant, 1 = ALU, 2 = MEM
   function automatic int exp_winner();
      if (alu_wb_valid && mem_wb_valid) begin
`ifdef MR_WB_RR_EN
         return m_rr ? 2 : 1;
`else
         return 2;
`endif
      end
      if (alu_wb_valid) return 1;
      if (mem_wb_valid) return 2;
      return 0;
   endfunction

   initial for (int i = 0; i < 32; i++) pend_m[i] = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) pend_m[i] = 0;
         err_m = 0; m_wbv = 0; m_wbr = '0; m_wbd = '0; m_rr = 0;
      end else begin
         m_win = exp_winner();
         m_inc = issue_valid && (issue_reg != 0) && (pend_m[issue_reg] < MAXP);
         if (m_wbv && m_inc && (issue_reg == m_wbr)) begin
            // issue and retire of the same register: net zero
         end else begin
            if (m_inc) pend_m[issue_reg]++;
            if (m_wbv) begin
               if (pend_m[m_wbr] > 0) pend_m[m_wbr]--;
               else err_m = 1;
            end
         end
`ifdef MR_WB_RR_EN
         if (alu_wb_valid && mem_wb_valid) m_rr = !m_rr;
`endif
         if (m_win == 1) begin
            m_wbv = (alu_wb_reg != 0); m_wbr = alu_wb_reg; m_wbd = alu_wb_val;
         end else if (m_win == 2) begin
            m_wbv = (mem_wb_reg != 0); m_wbr = mem_wb_reg; m_wbd = mem_wb_val;
         end else begin
            m_wbv = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_alu_ready", alu_wb_ready, 0);
         chk("rst_mem_ready", mem_wb_ready, 0);
         chk("rst_issue_ready", issue_ready, 0);
         chk("rst_wb_valid", wb_valid, 0);
         chk("rst_sb_err", sb_err, 0);
      end else begin
         chk("wb_valid", wb_valid, m_wbv);
         chk("wb_reg", wb_reg, m_wbr);
         chk("wb_val", wb_val, m_wbd);
         chk("sb_err", sb_err, err_m);
         chk("rs1_busy", rs1_busy, (rs1 != 0) && (pend_m[rs1] > 0));
         chk("rs2_busy", rs2_busy, (rs2 != 0) && (pend_m[rs2] > 0));
         chk("issue_ready", issue_ready, (issue_reg == 0) || (pend_m[issue_reg] < MAXP));
         if (alu_wb_valid && mem_wb_valid) begin
            chk("alu_ready_cont", alu_wb_ready, exp_winner() == 1);
            chk("mem_ready_cont", mem_wb_ready, exp_winner() == 2);
         end else if (alu_wb_valid) begin
            chk("alu_ready_solo", alu_wb_ready, 1);
         end else if (mem_wb_valid) begin
            chk("mem_ready_solo", mem_wb_ready, 1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [RS-1:0] r);
      issue_valid = 1'b1; issue_reg = r;
      step();
      issue_valid = 1'b0;
   endtask

   task automatic alu_wb(input logic [RS-1:0] r, input logic [XLEN-1:0] v);
      alu_wb_valid = 1'b1; alu_wb_reg = r; alu_wb_val = v;
      step();
      alu_wb_valid = 1'b0;
   endtask

   logic [RS-1:0]   aq_reg[$], mq_reg[$], logq[$];
   logic [XLEN-1:0] aq_val[$], mq_val[$];

   // Presents both queues, holding each head until it is accepted, and logs
   // the order of register-file writes. Bounded by max_cyc.
   task automatic run_streams(input int max_cyc);
      int  total;
      bit  acc_a, acc_m;
      logq.delete();
      total = aq_reg.size() + mq_reg.size();
      for (int c = 0; c < max_cyc; c++) begin
         alu_wb_valid = (aq_reg.size() > 0);
         if (alu_wb_valid) begin alu_wb_reg = aq_reg[0]; alu_wb_val = aq_val[0]; end
         mem_wb_valid = (mq_reg.size() > 0);
         if (mem_wb_valid) begin mem_wb_reg = mq_reg[0]; mem_wb_val = mq_val[0]; end
         @(negedge clk);
         if (wb_valid) logq.push_back(wb_reg);
         acc_a = alu_wb_valid && alu_wb_ready;
         acc_m = mem_wb_valid && mem_wb_ready;
         step();
         if (acc_a) begin void'(aq_reg.pop_front()); void'(aq_val.pop_front()); end
         if (acc_m) begin void'(mq_reg.pop_front()); void'(mq_val.pop_front()); end
         if (logq.size() == total) break;
      end
      alu_wb_valid = 1'b0;
      mem_wb_valid = 1'b0;
      chk("stream_len", logq.size(), total);
   endtask

   function automatic logic [31:0] log_at(input int i);
      return (i < logq.size()) ? 32'(logq[i]) : 32'hFFFF_FFFF;
   endfunction

   // ---------------- directed sequence ----------------
   logic [RS-1:0] exp_pair [2];
   logic [RS-1:0] exp_strm [4];
   logic [RS-1:0] setup_regs [7];

   initial begin
`ifdef MR_WB_RR_EN
      exp_pair = '{5'd3, 5'd4};
      exp_strm = '{5'd18, 5'd16, 5'd19, 5'd17};
`else
      exp_pair = '{5'd4, 5'd3};
      exp_strm = '{5'd18, 5'd19, 5'd16, 5'd17};
`endif
      setup_regs = '{5'd5, 5'd3, 5'd4, 5'd16, 5'd17, 5'd18, 5'd19};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_wb_valid", wb_valid, 0);
      chk("reset_wb_reg", wb_reg, 0);
      chk("reset_wb_val", wb_val, 0);
      chk("reset_sb_err", sb_err, 0);
      chk("reset_alu_ready", alu_wb_ready, 0);
      chk("reset_mem_ready", mem_wb_ready, 0);
      chk("reset_issue_ready", issue_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Pre-issue every destination used by the arbitration tests
      foreach (setup_regs[i]) issue(setup_regs[i]);

      // ALU only
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd5; alu_wb_val = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("alu_only_ready", alu_wb_ready, 1);
      step();
      alu_wb_valid = 1'b0;
      @(negedge clk);
      chk("alu_only_wb_valid", wb_valid, 1);
      chk("alu_only_wb_reg", wb_reg, 5);
      chk("alu_only_wb_val", wb_val, 32'hDEAD_BEEF);
      step();
      @(negedge clk);
      chk("alu_only_wb_valid_drop", wb_valid, 0);
      step();

      // Single contested pair
      aq_reg = '{5'd3};  aq_val = '{32'h11};
      mq_reg = '{5'd4};  mq_val = '{32'h22};
      run_streams(8);
      for (int i = 0; i < 2; i++) chk($sformatf("pair_order%0d", i), log_at(i), 32'(exp_pair[i]));

      // Back-to-back contention
      aq_reg = '{5'd16, 5'd17}; aq_val = '{32'h33, 32'h55};
      mq_reg = '{5'd18, 5'd19}; mq_val = '{32'h44, 32'h66};
      run_streams(12);
      for (int i = 0; i < 4; i++) chk($sformatf("stream_order%0d", i), log_at(i), 32'(exp_strm[i]));

      // Scoreboard round-trip on reg 7
      issue_valid = 1'b1; issue_reg = 5'd7; rs1 = 5'd7;
      step();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("rt_busy_c1", rs1_busy, 1);
      step();
      step();
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd7; alu_wb_val = 32'h7777;
      @(negedge clk);
      chk("rt_alu_ready_c3", alu_wb_ready, 1);
      step();
      alu_wb_valid = 1'b0;
      @(negedge clk);
      chk("rt_wb_valid_c4", wb_valid, 1);
      chk("rt_wb_reg_c4", wb_reg, 7);
      chk("rt_busy_c4", rs1_busy, 1);
      step();
      @(negedge clk);
      chk("rt_busy_c5", rs1_busy, 0);
      step();

      // Saturation of reg 9 and x0 handling
      repeat (3) issue(5'd9);
      issue_reg = 5'd9;
      @(negedge clk);
      chk("sat_ready_r9", issue_ready, 0);
      issue_reg = 5'd10; #1;
      chk("sat_ready_r10", issue_ready, 1);
      issue_reg = 5'd0; #1;
      chk("sat_ready_r0", issue_ready, 1);
      issue(5'd9);                       // refused: must not overflow
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd0; alu_wb_val = 32'h77; rs1 = 5'd0;
      @(negedge clk);
      chk("x0_ready", alu_wb_ready, 1);
      chk("x0_rs1_busy", rs1_busy, 0);
      step();
      alu_wb_valid = 1'b0;
      @(negedge clk);
      chk("x0_no_wb_valid", wb_valid, 0);
      step();
      rs1 = 5'd9;
      repeat (3) alu_wb(5'd9, 32'h99);
      step();
      @(negedge clk);
      chk("sat_drained_r9", rs1_busy, 0);
      step();

      // Simultaneous issue and writeback of reg 2
      issue(5'd2);
      alu_wb(5'd2, 32'h2222);
      issue_valid = 1'b1; issue_reg = 5'd2; rs1 = 5'd2;
      @(negedge clk);
      chk("simul_wb_valid", wb_valid, 1);
      step();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("simul_busy_kept", rs1_busy, 1);
      step();
      alu_wb(5'd2, 32'h2223);
      step();
      @(negedge clk);
      chk("simul_busy_cleared", rs1_busy, 0);
      chk("uflow_err_before", sb_err, 0);
      step();

      // Underflow on reg 12
      alu_wb(5'd12, 32'hC);
      step();
      @(negedge clk);
      chk("uflow_err_set", sb_err, 1);
      repeat (3) step();
      @(negedge clk);
      chk("uflow_err_sticky", sb_err, 1);
      step();

      // Asynchronous reset in the middle of a write to reg 6 (pend = 2)
      repeat (2) issue(5'd6);
      rs1 = 5'd6;
      alu_wb_valid = 1'b1; alu_wb_reg = 5'd6; alu_wb_val = 32'h66;
      step();
      alu_wb_valid = 1'b0;
      #1;
      chk("arst_pre_wb_valid", wb_valid, 1);
      chk("arst_pre_busy", rs1_busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_wb_valid", wb_valid, 0);
      chk("arst_busy", rs1_busy, 0);
      chk("arst_sb_err", sb_err, 0);
      chk("arst_alu_ready", alu_wb_ready, 0);
      chk("arst_issue_ready", issue_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) step();
      @(negedge clk);
      chk("arst_after_busy", rs1_busy, 0);
      chk("arst_after_err", sb_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_mr_wb_ctrl
`default_nettype wire
